aoi_exerciser: RTL and testbench

AOI_EXERCISER -- requirements
Module: aoi_exerciser

---
 rtl/aoi_pkg.sv | 15 +
 rtl/aoi_ref_model.sv | 19 +
 rtl/aoi_exerciser.sv | 138 +++++++++++++
 tb/tb_aoi_exerciser.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/aoi_pkg.sv
// Shared definitions for the AOI exerciser: sweep FSM states and widths.
package aoi_pkg;

  localparam int unsigned VEC_W          = 4;
  localparam int unsigned ERR_W          = 5;
  localparam int unsigned SETTLE_DEFAULT = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } state_e;

endpackage

// File: rtl/aoi_ref_model.sv
// Golden combinational model of the 4-input AOI: G = ~((A&B) | (C&D)).
module aoi_ref_model (
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  output logic exp_e,
  output logic exp_f,
  output logic exp_g
);

  // Expected internal AND nodes and the inverted OR output.
  always_comb begin
    exp_e = a & b;
    exp_f = c & d;
    exp_g = ~(exp_e | exp_f);
  end

endmodule

// File: rtl/aoi_exerciser.sv
// Sweeps all 16 input vectors through an external AOI, holds each for
// SETTLE cycles, then checks the observed E/F/G nodes against a reference.
module aoi_exerciser
  import aoi_pkg::*;
#(
  parameter int unsigned SETTLE = SETTLE_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             d,
  input  logic             e_in,
  input  logic             f_in,
  input  logic             g_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             fail_valid,
  output logic [VEC_W-1:0] fail_vec
);

  localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [ERR_W-1:0] ERR_MAX     = ERR_W'(16);
  localparam logic [VEC_W-1:0] VEC_LAST    = '1;

  state_e           state_q, state_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             fail_valid_q, fail_valid_d;
  logic [VEC_W-1:0] fail_vec_q, fail_vec_d;
  logic             done_q, done_d;

  logic exp_e, exp_f, exp_g;
  logic vec_fail;

  aoi_ref_model u_ref (
    .a     (vec_q[3]),
    .b     (vec_q[2]),
    .c     (vec_q[1]),
    .d     (vec_q[0]),
    .exp_e (exp_e),
    .exp_f (exp_f),
    .exp_g (exp_g)
  );

  // One failing vector counts once regardless of how many nodes disagree.
  always_comb begin
    vec_fail = (e_in != exp_e) | (f_in != exp_f) | (g_in != exp_g);
  end

  // Next-state and datapath updates for the sweep FSM.
  always_comb begin
    state_d      = state_q;
    vec_d        = vec_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    fail_valid_d = fail_valid_q;
    fail_vec_d   = fail_vec_q;
    done_d       = done_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d      = ST_SETTLE;
          vec_d        = '0;
          cnt_d        = '0;
          err_d        = '0;
          fail_valid_d = 1'b0;
          fail_vec_d   = '0;
          done_d       = 1'b0;
        end
      end
      ST_SETTLE: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == SETTLE_LAST) begin
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (vec_fail) begin
          if (err_q != ERR_MAX) begin
            err_d = err_q + ERR_W'(1);
          end
          if (!fail_valid_q) begin
            fail_valid_d = 1'b1;
            fail_vec_d   = vec_q;
          end
        end
        if (vec_q != VEC_LAST) begin
          vec_d   = vec_q + VEC_W'(1);
          cnt_d   = '0;
          state_d = ST_SETTLE;
        end else begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      vec_q        <= '0;
      cnt_q        <= '0;
      err_q        <= '0;
      fail_valid_q <= 1'b0;
      fail_vec_q   <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      vec_q        <= vec_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      fail_valid_q <= fail_valid_d;
      fail_vec_q   <= fail_vec_d;
      done_q       <= done_d;
    end
  end

  // Output decode from the registered state.
  always_comb begin
    {a, b, c, d} = vec_q;
    busy         = (state_q == ST_SETTLE) || (state_q == ST_CHECK);
    done         = done_q;
    pass         = done_q && (err_q == '0);
    err_count    = err_q;
    fail_valid   = fail_valid_q;
    fail_vec     = fail_vec_q;
  end

endmodule

// File: tb/tb_aoi_exerciser.sv
// Directed bench: two exercisers (SETTLE=2 with selectable AOI fault,
// SETTLE=1 with a clean AOI); expected sweep results queued at start.
module tb_aoi_exerciser;

  typedef struct {
    int lat;
    int errs;
    int fvalid;
    int fvec;
    int pass;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start1, start2;
  logic       a1, b1, c1, d1, e1, f1, g1;
  logic       busy1, done1, pass1, fail_valid1;
  logic [4:0] err1;
  logic [3:0] fvec1;
  logic       a2, b2, c2, d2, e2, f2, g2;
  logic       busy2, done2, pass2, fail_valid2;
  logic [4:0] err2;
  logic [3:0] fvec2;

  int   fault_mode = 0;
  int   total = 0;
  int   bad = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  aoi_exerciser #(.SETTLE(2)) dut1 (
    .clk(clk), .rst(rst), .start(start1),
    .a(a1), .b(b1), .c(c1), .d(d1),
    .e_in(e1), .f_in(f1), .g_in(g1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .fail_valid(fail_valid1), .fail_vec(fvec1)
  );

  aoi_exerciser #(.SETTLE(1)) dut2 (
    .clk(clk), .rst(rst), .start(start2),
    .a(a2), .b(b2), .c(c2), .d(d2),
    .e_in(e2), .f_in(f2), .g_in(g2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
    .fail_valid(fail_valid2), .fail_vec(fvec2)
  );

  // AOI attached to dut1: 0 = healthy, 1 = G stuck-at-1, 2 = E stuck-at-0.
  always_comb begin
    e1 = (fault_mode == 2) ? 1'b0 : (a1 & b1);
    f1 = c1 & d1;
    g1 = (fault_mode == 1) ? 1'b1 : ~(e1 | f1);
  end

  always_comb begin
    e2 = a2 & b2;
    f2 = c2 & d2;
    g2 = ~(e2 | f2);
  end

  function automatic exp_t predict(input int fault, input int settle);
    exp_t r;
    r.lat = 16 * (settle + 1);
    r.errs = 0;
    r.fvalid = 0;
    r.fvec = 0;
    for (int v = 0; v < 16; v++) begin
      bit va, vb, vc, vd, ge, gf, gg, oe, of_, og;
      va = v[3]; vb = v[2]; vc = v[1]; vd = v[0];
      ge = va && vb;
      gf = vc && vd;
      gg = !(ge || gf);
      oe = (fault == 2) ? 1'b0 : ge;
      of_ = gf;
      og = (fault == 1) ? 1'b1 : !(oe || of_);
      if (oe != ge || of_ != gf || og != gg) begin
        r.errs++;
        if (r.fvalid == 0) begin
          r.fvalid = 1;
          r.fvec = v;
        end
      end
    end
    r.pass = (r.errs == 0) ? 1 : 0;
    return r;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset1(input string tag);
    chk({tag, "_abcd"}, int'({a1, b1, c1, d1}), 0);
    chk({tag, "_busy"}, int'(busy1), 0);
    chk({tag, "_done"}, int'(done1), 0);
    chk({tag, "_pass"}, int'(pass1), 0);
    chk({tag, "_err"}, int'(err1), 0);
    chk({tag, "_fvalid"}, int'(fail_valid1), 0);
    chk({tag, "_fvec"}, int'(fvec1), 0);
  endtask

  // Sweep on dut1; optional start re-pulse and reset at given edge numbers.
  task automatic run1(input int fault, input int repulse_at, input int rst_at);
    exp_t e;
    int n;
    bit hit;
    fault_mode = fault;
    sb.push_back(predict(fault, 2));
    start1 = 1'b1;
    edge1();
    start1 = 1'b0;
    chk("start_busy", int'(busy1), 1);
    chk("start_done_clr", int'(done1), 0);
    chk("start_err_clr", int'(err1), 0);
    chk("start_fvalid_clr", int'(fail_valid1), 0);
    n = 0;
    hit = 1'b0;
    while (!hit && n < 200) begin
      if (n == repulse_at) start1 = 1'b1;
      edge1();
      start1 = 1'b0;
      n++;
      if (n == rst_at) begin
        rst = 1'b1;
        edge1();
        rst = 1'b0;
        chk_reset1("midreset");
        void'(sb.pop_back());
        return;
      end
      hit = done1;
    end
    if (!hit) chk("done_timeout", 0, 1);
    e = sb.pop_front();
    chk("latency", n, e.lat);
    chk("err_count", int'(err1), e.errs);
    chk("fail_valid", int'(fail_valid1), e.fvalid);
    chk("fail_vec", int'(fvec1), e.fvec);
    chk("pass", int'(pass1), e.pass);
    chk("busy_after", int'(busy1), 0);
    chk("vec_hold15", int'({a1, b1, c1, d1}), 15);
  endtask

  task automatic run2();
    exp_t e;
    int n;
    bit hit;
    sb.push_back(predict(0, 1));
    start2 = 1'b1;
    edge1();
    start2 = 1'b0;
    n = 0;
    hit = 1'b0;
    while (!hit && n < 100) begin
      edge1();
      n++;
      if (!done2 && n < 32) chk("s1_vec_step", int'({a2, b2, c2, d2}), n / 2);
      hit = done2;
    end
    if (!hit) chk("s1_done_timeout", 0, 1);
    e = sb.pop_front();
    chk("s1_latency", n, e.lat);
    chk("s1_err_count", int'(err2), e.errs);
    chk("s1_fail_valid", int'(fail_valid2), e.fvalid);
    chk("s1_pass", int'(pass2), e.pass);
  endtask

  initial begin
    rst = 1'b1;
    start1 = 1'b0;
    start2 = 1'b0;
    repeat (3) edge1();
    chk_reset1("reset");
    rst = 1'b0;
    edge1();

    run1(0, -1, -1);
    run1(1, -1, -1);
    run1(2, -1, -1);
    run1(1, -1, 20);
    run1(0, -1, -1);
    run1(0, 10, -1);

    // Reset wins over a coincident start.
    rst = 1'b1;
    start1 = 1'b1;
    edge1();
    rst = 1'b0;
    start1 = 1'b0;
    chk("rst_prio_busy", int'(busy1), 0);
    chk("rst_prio_done", int'(done1), 0);
    edge1();
    chk("rst_prio_idle", int'(busy1), 0);

    run2();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
